// File: rtl/flight_sequencer.sv
// rtl/flight_sequencer.sv - mission-phase controller with one-second timebase and sample channel
module flight_sequencer #(
    parameter int               N             = 64,
    parameter int               TICKS_PER_SEC = 1000,
    parameter logic [N-1:0]     GIMBAL_HEIGHT = 64'd30_000_000_000,
    parameter int               T_MAX         = 600
) (
    input  logic         CLK,
    input  logic         RESETB,
    input  logic         launch,
    input  logic         abort,
    input  logic [15:0]  burntime,
    input  logic [N-1:0] height,
    input  logic         sample_ready,
    output logic         integ_en,
    output logic         burning,
    output logic         gimbal_en,
    output logic [15:0]  elapsed,
    output logic         sec_tick,
    output logic         gimbal_evt,
    output logic         burnout_evt,
    output logic [2:0]   state,
    output logic         sample_valid,
    output logic [15:0]  sample_time,
    output logic         overrun
);

    localparam int              PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [15:0]     T_MAX_W    = 16'(T_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BURN   = 3'd1,
        S_GIMBAL = 3'd2,
        S_COAST  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [PW-1:0]  presc;
    logic [15:0]    burntime_q;
    logic           via_gimbal;
    logic           in_flight;
    logic           count_en;
    logic           wrap;
    logic           start;
    logic [15:0]    elapsed_inc;

    assign state       = state_q;
    assign in_flight   = (state_q == S_BURN) || (state_q == S_GIMBAL) || (state_q == S_COAST);
    // The timebase freezes on the edge that enters DONE so an abort never bumps elapsed.
    assign count_en    = in_flight && (state_d != S_DONE);
    assign wrap        = count_en && (presc == PRESC_LAST);
    assign start       = (state_q == S_IDLE) && (state_d == S_BURN);
    assign elapsed_inc = (elapsed == 16'hFFFF) ? elapsed : elapsed + 16'd1;

    // Next-state decision from registered values; abort first, burnout before gimbal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (launch) state_d = S_BURN;
            S_BURN: begin
                if (abort)                          state_d = S_DONE;
                else if (elapsed == burntime_q)     state_d = S_COAST;
                else if (height >= GIMBAL_HEIGHT)   state_d = S_GIMBAL;
            end
            S_GIMBAL: begin
                if (abort)                          state_d = S_DONE;
                else if (elapsed == burntime_q)     state_d = S_COAST;
            end
            S_COAST: begin
                if (abort)                          state_d = S_DONE;
                else if (elapsed == T_MAX_W)        state_d = S_DONE;
            end
            S_DONE:   state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register, phase flag and registered phase outputs.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q     <= S_IDLE;
            via_gimbal  <= 1'b0;
            burntime_q  <= 16'd0;
            integ_en    <= 1'b0;
            burning     <= 1'b0;
            gimbal_en   <= 1'b0;
            gimbal_evt  <= 1'b0;
            burnout_evt <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (start) begin
                burntime_q <= burntime;
                via_gimbal <= 1'b0;
            end else if (state_d == S_GIMBAL) begin
                via_gimbal <= 1'b1;
            end
            integ_en    <= (state_d == S_BURN) || (state_d == S_GIMBAL) || (state_d == S_COAST);
            burning     <= (state_d == S_BURN) || (state_d == S_GIMBAL);
            gimbal_en   <= (state_d == S_GIMBAL) || ((state_d == S_COAST) && via_gimbal);
            gimbal_evt  <= (state_q == S_BURN) && (state_d == S_GIMBAL);
            burnout_evt <= (state_q != S_COAST) && (state_d == S_COAST);
        end
    end

    // One-second prescaler and saturating elapsed-seconds counter.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            presc    <= '0;
            elapsed  <= 16'd0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= wrap;
            if (start) begin
                presc   <= '0;
                elapsed <= 16'd0;
            end else if (wrap) begin
                presc   <= '0;
                elapsed <= elapsed_inc;
            end else if (count_en) begin
                presc   <= presc + 1'b1;
            end
        end
    end

    // Per-second sample record; a new tick replaces an unaccepted one and flags the loss.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            sample_valid <= 1'b0;
            sample_time  <= 16'd0;
            overrun      <= 1'b0;
        end else if (wrap) begin
            sample_valid <= 1'b1;
            sample_time  <= elapsed_inc;
            if (sample_valid && !sample_ready) overrun <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flight_sequencer.sv
// tb/tb_flight_sequencer.sv - randomized bench with behavioural flight model for flight_sequencer
module tb_flight_sequencer;

    localparam int          N   = 64;
    localparam int          TPS = 4;
    localparam int          TM  = 40;
    localparam logic [63:0] GH  = 64'd30_000_000_000;

    logic         CLK = 1'b0;
    logic         RESETB = 1'b0;
    logic         launch = 1'b0;
    logic         abort = 1'b0;
    logic [15:0]  burntime = 16'd0;
    logic [N-1:0] height = '0;
    logic         sample_ready = 1'b0;
    logic         integ_en, burning, gimbal_en, sec_tick, gimbal_evt, burnout_evt;
    logic         sample_valid, overrun;
    logic [15:0]  elapsed, sample_time;
    logic [2:0]   state;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    flight_sequencer #(.N(N), .TICKS_PER_SEC(TPS), .GIMBAL_HEIGHT(GH), .T_MAX(TM)) dut (
        .CLK(CLK), .RESETB(RESETB), .launch(launch), .abort(abort), .burntime(burntime),
        .height(height), .sample_ready(sample_ready), .integ_en(integ_en), .burning(burning),
        .gimbal_en(gimbal_en), .elapsed(elapsed), .sec_tick(sec_tick), .gimbal_evt(gimbal_evt),
        .burnout_evt(burnout_evt), .state(state), .sample_valid(sample_valid),
        .sample_time(sample_time), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: phase from the flight rules, time as counted cycles / TPS.
    int      m_state = 0;
    longint  m_cnt = 0;
    int      m_elapsed = 0;
    int      m_burn = 0;
    bit      m_tick = 0, m_gevt = 0, m_bevt = 0, m_vg = 0, m_valid = 0, m_over = 0;
    int      m_time = 0;

    always @(posedge CLK or negedge RESETB) begin : model
        int  nxt;
        bit  counted;
        longint el;
        if (!RESETB) begin
            m_state = 0; m_cnt = 0; m_elapsed = 0; m_burn = 0;
            m_tick = 0; m_gevt = 0; m_bevt = 0; m_vg = 0;
            m_valid = 0; m_over = 0; m_time = 0;
        end else begin
            nxt = m_state;
            if (m_state == 0) begin
                if (launch) nxt = 1;
            end else if (m_state != 4 && abort) begin
                nxt = 4;
            end else if ((m_state == 1 || m_state == 2) && m_elapsed == m_burn) begin
                nxt = 3;
            end else if (m_state == 1 && height >= GH) begin
                nxt = 2;
            end else if (m_state == 3 && m_elapsed == TM) begin
                nxt = 4;
            end
            counted = (m_state >= 1 && m_state <= 3) && nxt != 4;
            m_gevt  = (nxt == 2) && (m_state != 2);
            m_bevt  = (nxt == 3) && (m_state != 3);
            if (m_state == 0 && nxt == 1) begin
                m_cnt = 0; m_burn = int'(burntime); m_vg = 0;
            end else if (counted) begin
                m_cnt++;
            end
            m_tick = counted && (m_cnt % TPS == 0);
            el = m_cnt / TPS;
            if (el > 65535) el = 65535;
            if (m_tick) begin
                if (m_valid && !sample_ready) m_over = 1;
                m_valid = 1;
                m_time  = int'(el);
            end else if (m_valid && sample_ready) begin
                m_valid = 0;
            end
            if (nxt == 2) m_vg = 1;
            m_elapsed = int'(el);
            m_state   = nxt;
        end
    end

    // Compare every output with the model away from the active edge.
    always @(negedge CLK) begin
        if (chk_on) begin
            chk("state",        state,        m_state);
            chk("integ_en",     integ_en,     (m_state >= 1 && m_state <= 3));
            chk("burning",      burning,      (m_state == 1 || m_state == 2));
            chk("gimbal_en",    gimbal_en,    (m_state == 2 || (m_state == 3 && m_vg)));
            chk("elapsed",      elapsed,      m_elapsed);
            chk("sec_tick",     sec_tick,     m_tick);
            chk("gimbal_evt",   gimbal_evt,   m_gevt);
            chk("burnout_evt",  burnout_evt,  m_bevt);
            chk("sample_valid", sample_valid, m_valid);
            chk("sample_time",  sample_time,  m_time);
            chk("overrun",      overrun,      m_over);
        end
    end

    task automatic do_reset();
        @(negedge CLK); #1;
        RESETB = 1'b0; launch = 1'b0; abort = 1'b0; height = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        RESETB = 1'b1;
    endtask

    task automatic do_launch(input logic [15:0] bt);
        burntime = bt; launch = 1'b1;
        @(posedge CLK); #1;
        launch = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic wait_el(input int tgt);
        int n = 0;
        while (elapsed != tgt && n < 2000) begin step(); n++; end
        chk("wait_elapsed", elapsed, tgt);
    endtask

    task automatic wait_st(input int tgt);
        int n = 0;
        while (state != tgt && n < 2000) begin step(); n++; end
        chk("wait_state", state, tgt);
    endtask

    initial begin
        do_reset();
        chk_on = 1'b1;
        chk("rst_state", state, 0);
        chk("rst_elapsed", elapsed, 0);

        // Basic burn: elapsed=3 after 12 cycles, COAST one edge later, then DONE at T_MAX.
        sample_ready = 1'b1;
        do_launch(16'd3);
        chk("lit_burn", state, 1);
        repeat (12) step();
        chk("lit_el3", elapsed, 3);
        chk("lit_still_burn", state, 1);
        step();
        chk("lit_coast", state, 3);
        chk("lit_burnout_evt", burnout_evt, 1);
        chk("lit_integ", integ_en, 1);
        chk("lit_burning", burning, 0);
        wait_st(4);
        chk("lit_done_el", elapsed, TM);
        chk("lit_done_integ", integ_en, 0);
        chk("lit_no_overrun", overrun, 0);
        launch = 1'b1; repeat (3) step(); launch = 1'b0;
        chk("lit_done_hold", state, 4);

        // Gimbal phase entered at elapsed=2, kept through COAST.
        do_reset();
        do_launch(16'd10);
        wait_el(2);
        height = GH;
        step();
        chk("lit_gimbal", state, 2);
        chk("lit_gimbal_evt", gimbal_evt, 1);
        chk("lit_gimbal_en", gimbal_en, 1);
        wait_st(3);
        chk("lit_coast_gen", gimbal_en, 1);
        chk("lit_coast_el", elapsed, 10);
        wait_st(4);
        chk("lit_done_gen", gimbal_en, 0);

        // Threshold crossing on the burnout cycle: burnout wins.
        do_reset();
        do_launch(16'd3);
        wait_el(3);
        height = GH;
        step();
        chk("lit_race_state", state, 3);
        chk("lit_race_gevt", gimbal_evt, 0);
        chk("lit_race_gen", gimbal_en, 0);

        // burntime=0: one BURN cycle then COAST.
        do_reset();
        do_launch(16'd0);
        chk("lit_bt0_burn", state, 1);
        step();
        chk("lit_bt0_coast", state, 3);
        chk("lit_bt0_evt", burnout_evt, 1);

        // Logger stalled for two ticks.
        do_reset();
        sample_ready = 1'b0;
        do_launch(16'd20);
        wait_el(2);
        chk("lit_smp_valid", sample_valid, 1);
        chk("lit_smp_time", sample_time, 2);
        chk("lit_overrun", overrun, 1);
        sample_ready = 1'b1;
        step();
        chk("lit_smp_clear", sample_valid, 0);

        // Abort in GIMBAL at elapsed=5.
        do_reset();
        do_launch(16'd10);
        wait_el(2);
        height = GH;
        wait_el(5);
        chk("lit_ab_gimbal", state, 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("lit_ab_done", state, 4);
        chk("lit_ab_el", elapsed, 5);
        chk("lit_ab_integ", integ_en, 0);
        chk("lit_ab_gen", gimbal_en, 0);
        launch = 1'b1; repeat (8) step(); launch = 1'b0;
        chk("lit_ab_frozen", elapsed, 5);
        chk("lit_ab_hold", state, 4);

        // Asynchronous reset mid-BURN, then relaunch.
        do_reset();
        height = '0;
        do_launch(16'd10);
        repeat (6) step();
        #1 RESETB = 1'b0;
        #1;
        chk("lit_async_state", state, 0);
        chk("lit_async_el", elapsed, 0);
        chk("lit_async_integ", integ_en, 0);
        @(posedge CLK); @(negedge CLK); #1 RESETB = 1'b1;
        do_launch(16'd10);
        chk("lit_relaunch", state, 1);
        chk("lit_relaunch_el", elapsed, 0);

        // Randomized flights against the model.
        for (int f = 0; f < 8; f++) begin
            do_reset();
            do_launch(16'($urandom_range(0, 25)));
            for (int c = 0; c < 260; c++) begin
                sample_ready = ($urandom_range(0, 3) != 0);
                abort        = ($urandom_range(0, 299) == 0);
                launch       = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 19) == 0) begin
                    case ($urandom_range(0, 4))
                        0: height = '0;
                        1: height = GH - 64'd1;
                        2: height = GH;
                        3: height = GH + 64'd1;
                        default: height = {$urandom, $urandom};
                    endcase
                end
                step();
            end
            abort = 1'b0; launch = 1'b0;
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
